posit_add_arbiter: RTL

// Shares one fully pipelined, non-stalling 32-bit posit adder (start/done, fixed latency) among NREQ requesters.

---
 rtl/posit_add_arbiter_pkg.sv | 28 ++
 rtl/posit_add_arbiter_rr.sv | 41 ++++
 rtl/posit_add_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/posit_add_arbiter_pkg.sv
// Shared definitions for the posit adder arbiter slice.
//   ADD_LATENCY : start->done latency of the shared posit adder
//   TAG_ID_W    : width of the requester id carried in the tag pipe (up to 16 requesters)
//   add_tag_t   : one tag pipe stage, {valid, requester id}
//   wrap_idx    : (base + off) mod n for 0 <= base < n, 0 <= off <= n
package posit_add_arbiter_pkg;

    localparam int ADD_LATENCY = 8;
    localparam int TAG_ID_W    = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } add_tag_t;

    // Explicit modulo wrap so non-power-of-two requester counts never produce ids >= n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/posit_add_arbiter_rr.sv
// Combinational round-robin arbiter.
//   req      : request vector
//   ptr      : last granted index; the search starts at ptr+1 (mod N)
//   grant    : one-hot grant, zero when no request
//   grant_id : index of the granted request (0 when none)
//   any      : at least one request granted
module rr_arbiter
    import posit_add_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_id,
    output logic          any
);

    // Scan N positions starting one past the pointer; the first requester found wins.
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        grant    = '0;
        grant_id = '0;
        hit      = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'(wrap_idx(int'(ptr), k, N));
            if (!hit && req[idx]) begin
                hit        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end else begin
                hit = hit;
            end
        end
        any = hit;
    end

endmodule

// File: rtl/posit_add_arbiter.sv
// Shares one fully pipelined, fixed-latency posit adder among NREQ requesters.
// Round-robin issue of at most one operation per cycle; a tag pipe as deep as the
// adder latency returns each result with the id of the requester that issued it.
//   clk, reset               : clock, synchronous active-high reset
//   req_valid/req_ready      : per-requester handshake (ready is the combinational grant)
//   req_in1/req_in2          : packed operands, requester i at [32*i+:32]
//   add_in1/add_in2/add_start: towards the adder (combinational, the adder registers them)
//   add_result/inf/zero/done : from the adder
//   rsp_valid/id/result/inf/zero : in-order response, single cycle, no backpressure
//   busy                     : at least one operation in flight
//   err_sync                 : sticky, add_done disagreed with the tag pipe
module posit_add_arbiter
    import posit_add_arbiter_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int LATENCY = ADD_LATENCY,
    localparam int IDW     = $clog2(NREQ),
    localparam int CW      = $clog2(LATENCY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_in1,
    input  logic [NREQ*32-1:0] req_in2,
    output logic [31:0]        add_in1,
    output logic [31:0]        add_in2,
    output logic               add_start,
    input  logic [31:0]        add_result,
    input  logic               add_inf,
    input  logic               add_zero,
    input  logic               add_done,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_inf,
    output logic               rsp_zero,
    output logic               busy,
    output logic               err_sync
);

    logic [NREQ-1:0] req_gated;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic [IDW-1:0]  ptr;
    add_tag_t        tag_q [LATENCY];
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   warmup;
    logic            retire;

    // Nothing is granted while reset is high.
    always_comb begin
        if (reset) begin
            req_gated = '0;
        end else begin
            req_gated = req_valid;
        end
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req      (req_gated),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    assign req_ready = grant;
    assign add_start = grant_any;
    assign retire    = tag_q[LATENCY-1].valid;

    // Operand mux for the granted requester; idle cycles drive zero operands.
    always_comb begin
        add_in1 = 32'h0000_0000;
        add_in2 = 32'h0000_0000;
        if (grant_any) begin
            add_in1 = req_in1[int'(grant_id)*32 +: 32];
            add_in2 = req_in2[int'(grant_id)*32 +: 32];
        end else begin
            add_in1 = 32'h0000_0000;
            add_in2 = 32'h0000_0000;
        end
    end

    // Round-robin pointer: remembers the last accepted requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= IDW'(NREQ - 1);
        end else if (grant_any) begin
            ptr <= grant_id;
        end else begin
            ptr <= ptr;
        end
    end

    // Tag pipe: stage 0 records every cycle's issue slot, the last stage lines up with add_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= grant_any;
            tag_q[0].id    <= TAG_ID_W'(grant_id);
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // In-flight counter: issue and retire in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({grant_any, retire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Warmup: the adder has no reset, so operations issued before reset may still
    // emerge for up to LATENCY cycles; done checking is masked until this reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            warmup <= CW'(LATENCY);
        end else if (warmup != '0) begin
            warmup <= warmup - CW'(1);
        end else begin
            warmup <= warmup;
        end
    end

    // Sticky tag/done disagreement flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sync <= 1'b0;
        end else if ((warmup == '0) && (add_done != retire)) begin
            err_sync <= 1'b1;
        end else begin
            err_sync <= err_sync;
        end
    end

    // Response and busy outputs, forced idle while reset is high.
    always_comb begin
        if (reset) begin
            rsp_valid = 1'b0;
            busy      = 1'b0;
        end else begin
            rsp_valid = retire;
            busy      = (inflight != '0);
        end
    end

    assign rsp_id     = tag_q[LATENCY-1].id[IDW-1:0];
    assign rsp_result = add_result;
    assign rsp_inf    = add_inf;
    assign rsp_zero   = add_zero;

endmodule
